// File: rtl/usb_buf_pkg.sv
// Shared types and helpers for the USB endpoint buffer access controller.
package usb_buf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    AHB_GNT = 2'd1,
    USB_GNT = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_1B  = 2'd0;
  localparam logic [1:0] SIZE_2B  = 2'd1;
  localparam logic [1:0] SIZE_4B  = 2'd2;
  localparam logic [1:0] SIZE_BAD = 2'd3;

  // Byte count of an AHB access; the illegal size maps to zero.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    logic [2:0] bytes;
    case (size)
      SIZE_1B: bytes = 3'd1;
      SIZE_2B: bytes = 3'd2;
      SIZE_4B: bytes = 3'd4;
      default: bytes = 3'd0;
    endcase
    return bytes;
  endfunction

endpackage

// File: rtl/buffer_occupancy_counter.sv
// Byte occupancy register for the endpoint buffer; clear wins over inc/dec.
module buffer_occupancy_counter
  import usb_buf_pkg::*;
#(
  parameter int unsigned BUFFER_BYTES = 64,
  localparam int unsigned OCC_W = $clog2(BUFFER_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic [2:0]       i_amt,
  output logic [OCC_W-1:0] o_occ,
  output logic             o_full,
  output logic             o_empty
);

  logic [OCC_W-1:0] r_occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
    end else if (i_clear) begin
      r_occ <= '0;
    end else if (i_inc) begin
      r_occ <= r_occ + OCC_W'(i_amt);
    end else if (i_dec) begin
      r_occ <= r_occ - OCC_W'(i_amt);
    end
  end

  assign o_occ   = r_occ;
  assign o_full  = (r_occ == OCC_W'(BUFFER_BYTES));
  assign o_empty = (r_occ == '0);

endmodule

// File: rtl/buffer_access_ctrl.sv
// Round-robin arbiter between AHB and USB requesters for the endpoint buffer,
// with overflow/underflow rejection, flush, and registered buffer strobes.
module buffer_access_ctrl
  import usb_buf_pkg::*;
#(
  parameter int unsigned BUFFER_BYTES = 64,
  localparam int unsigned OCC_W = $clog2(BUFFER_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ahb_req,
  input  logic             ahb_write,
  input  logic [1:0]       ahb_size,
  output logic             ahb_grant,
  output logic             ahb_err,
  input  logic             usb_req,
  input  logic             usb_write,
  output logic             usb_grant,
  output logic             usb_err,
  input  logic             flush,
  output logic             store_data,
  output logic             get_rx_data,
  output logic [1:0]       data_size,
  output logic             store_rx_packet_data,
  output logic             get_tx_packet_data,
  output logic             buffer_clear,
  output logic [OCC_W-1:0] buffer_occupancy,
  output logic             buffer_full,
  output logic             buffer_empty
);

  localparam logic [OCC_W:0] CAP = (OCC_W + 1)'(BUFFER_BYTES);

  state_t     r_state;
  logic       r_prio_usb;
  logic [2:0] w_ahb_bytes;
  logic [OCC_W:0] w_occ_ext;
  logic       w_ahb_legal;
  logic       w_usb_legal;
  logic       w_ahb_act;
  logic       w_usb_act;
  logic       w_ahb_cmp;
  logic       w_usb_cmp;
  logic       w_pick_ahb;
  logic       w_pick_usb;
  logic       w_inc;
  logic       w_dec;
  logic [2:0] w_amt;

  // Legality against the current occupancy; a requester is masked during its err cycle.
  assign w_ahb_bytes = size_to_bytes(ahb_size);
  assign w_occ_ext   = {1'b0, buffer_occupancy};
  assign w_ahb_legal = (ahb_size != SIZE_BAD) &&
                       (ahb_write ? ((w_occ_ext + (OCC_W + 1)'(w_ahb_bytes)) <= CAP)
                                  : (w_occ_ext >= (OCC_W + 1)'(w_ahb_bytes)));
  assign w_usb_legal = usb_write ? !buffer_full : !buffer_empty;
  assign w_ahb_act   = ahb_req && !ahb_err;
  assign w_usb_act   = usb_req && !usb_err;
  assign w_ahb_cmp   = w_ahb_act && w_ahb_legal;
  assign w_usb_cmp   = w_usb_act && w_usb_legal;
  assign w_pick_ahb  = w_ahb_cmp && (!w_usb_cmp || !r_prio_usb);
  assign w_pick_usb  = w_usb_cmp && !w_pick_ahb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state              <= IDLE;
      r_prio_usb           <= 1'b0;
      ahb_grant            <= 1'b0;
      ahb_err              <= 1'b0;
      usb_grant            <= 1'b0;
      usb_err              <= 1'b0;
      store_data           <= 1'b0;
      get_rx_data          <= 1'b0;
      data_size            <= 2'd0;
      store_rx_packet_data <= 1'b0;
      get_tx_packet_data   <= 1'b0;
      buffer_clear         <= 1'b0;
    end else begin
      r_state              <= IDLE;
      ahb_grant            <= 1'b0;
      ahb_err              <= 1'b0;
      usb_grant            <= 1'b0;
      usb_err              <= 1'b0;
      store_data           <= 1'b0;
      get_rx_data          <= 1'b0;
      data_size            <= 2'd0;
      store_rx_packet_data <= 1'b0;
      get_tx_packet_data   <= 1'b0;
      buffer_clear         <= 1'b0;
      if (flush) begin
        r_state      <= FLUSH;
        buffer_clear <= 1'b1;
      end else if (r_state == IDLE) begin
        ahb_err <= w_ahb_act && !w_ahb_legal;
        usb_err <= w_usb_act && !w_usb_legal;
        if (w_pick_ahb) begin
          r_state     <= AHB_GNT;
          ahb_grant   <= 1'b1;
          store_data  <= ahb_write;
          get_rx_data <= !ahb_write;
          data_size   <= ahb_size;
          r_prio_usb  <= 1'b1;
        end else if (w_pick_usb) begin
          r_state              <= USB_GNT;
          usb_grant            <= 1'b1;
          store_rx_packet_data <= usb_write;
          get_tx_packet_data   <= !usb_write;
          r_prio_usb           <= 1'b0;
        end
      end
    end
  end

  // Occupancy moves on the edge that ends a grant cycle; flush clears it instead.
  assign w_inc = store_data || store_rx_packet_data;
  assign w_dec = get_rx_data || get_tx_packet_data;
  assign w_amt = (store_data || get_rx_data) ? size_to_bytes(data_size) : 3'd1;

  buffer_occupancy_counter #(
    .BUFFER_BYTES(BUFFER_BYTES)
  ) u_occ (
    .clk     (clk),
    .rst     (rst),
    .i_clear (flush),
    .i_inc   (w_inc),
    .i_dec   (w_dec),
    .i_amt   (w_amt),
    .o_occ   (buffer_occupancy),
    .o_full  (buffer_full),
    .o_empty (buffer_empty)
  );

endmodule
